// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence collector and its FIFO.
package seq_pkg;

    localparam int DATA_W    = 32;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_STREAM
    } state_e;

endpackage

// File: rtl/seq_fifo.sv
// Small synchronous FIFO with a registered occupancy count; head reads 0 when empty.
module seq_fifo
    import seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DATA_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the registered count, so a pop never frees a slot for a same-cycle push.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + OCC_W'(1);
            else if (do_pop && !do_push) count <= count - OCC_W'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the count alone decides which entries are valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/seq_collector.sv
// Drives the start/next generator, buffers returned samples and keeps their running sum.
module seq_collector
    import seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN_run,
    input  logic [CNT_W-1:0]  run_count,
    input  logic [DATA_W-1:0] run_k,
    output logic              RDY_run,
    output logic              up_EN_start,
    input  logic              up_RDY_start,
    output logic [DATA_W-1:0] up_next_k,
    output logic              up_EN_next,
    input  logic [DATA_W-1:0] up_next,
    input  logic              up_RDY_next,
    input  logic              EN_get,
    output logic [DATA_W-1:0] get,
    output logic              RDY_get,
    output logic [DATA_W-1:0] sum,
    output logic              busy
);

    state_e            state;
    state_e            next_state;
    logic [CNT_W-1:0]  remaining;
    logic [DATA_W-1:0] k_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept_run;

    assign RDY_run    = (state == ST_IDLE);
    assign busy       = !RDY_run;
    assign up_next_k  = k_q;
    assign RDY_get    = !fifo_empty;
    assign accept_run = RDY_run && EN_run && (run_count != '0);

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        next_state  = state;
        up_EN_start = 1'b0;
        up_EN_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept_run) next_state = ST_START;
            end
            ST_START: begin
                up_EN_start = up_RDY_start;
                if (up_RDY_start) next_state = ST_STREAM;
            end
            ST_STREAM: begin
                up_EN_next = up_RDY_next && !fifo_full;
                if (up_EN_next && remaining == CNT_W'(1)) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            remaining <= '0;
            k_q       <= '0;
            sum       <= '0;
        end else begin
            state <= next_state;
            if (accept_run) begin
                remaining <= run_count;
                k_q       <= run_k;
                sum       <= '0;
            end
            if (up_EN_next) begin
                remaining <= remaining - CNT_W'(1);
                sum       <= sum + up_next;
            end
        end
    end

    seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (up_EN_next),
        .push_data (up_next),
        .pop       (EN_get),
        .head      (get),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_seq_collector.sv
// Self-checking bench: vector table, directed corner sequences and a randomized run against a queue model.
module tb_seq_collector;

    localparam int DEPTH = 4;

    logic        CLK;
    logic        RST_N;
    logic        EN_run;
    logic [7:0]  run_count;
    logic [31:0] run_k;
    logic        RDY_run;
    logic        up_EN_start;
    logic        up_RDY_start;
    logic [31:0] up_next_k;
    logic        up_EN_next;
    logic [31:0] up_next;
    logic        up_RDY_next;
    logic        EN_get;
    logic [31:0] get;
    logic        RDY_get;
    logic [31:0] sum;
    logic        busy;

    seq_collector #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .EN_run       (EN_run),
        .run_count    (run_count),
        .run_k        (run_k),
        .RDY_run      (RDY_run),
        .up_EN_start  (up_EN_start),
        .up_RDY_start (up_RDY_start),
        .up_next_k    (up_next_k),
        .up_EN_next   (up_EN_next),
        .up_next      (up_next),
        .up_RDY_next  (up_RDY_next),
        .EN_get       (EN_get),
        .get          (get),
        .RDY_get      (RDY_get),
        .sum          (sum),
        .busy         (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: samples still owed, whether start has fired, buffered values, sum, k.
    int          m_left;
    bit          m_started;
    logic [31:0] m_q[$];
    logic [31:0] m_sum;
    logic [31:0] m_k;

    // Generator model for directed sequences.
    bit          use_gen;
    logic [31:0] gen_vals[$];
    int          gen_idx;

    // Observations taken from the DUT during directed sequences.
    int          n_fire;
    int          n_start;
    logic [31:0] dut_got[$];

    // One clock: settle, compare against model, advance model on the edge, return at negedge.
    task automatic tick(input bit do_check);
        bit          e_busy, e_en_start, e_en_next, e_rdy_get;
        logic [31:0] e_get;
        if (use_gen) up_next = (gen_idx < gen_vals.size()) ? gen_vals[gen_idx] : 32'hDEAD_0000 + 32'(gen_idx);
        #1;
        e_busy     = (m_left != 0);
        e_en_start = e_busy && !m_started && up_RDY_start;
        e_en_next  = e_busy && m_started && up_RDY_next && (m_q.size() < DEPTH);
        e_rdy_get  = (m_q.size() != 0);
        e_get      = e_rdy_get ? m_q[0] : 32'd0;
        if (do_check) begin
            check("RDY_run",     32'(RDY_run),     32'(!e_busy));
            check("busy",        32'(busy),        32'(e_busy));
            check("up_EN_start", 32'(up_EN_start), 32'(e_en_start));
            check("up_EN_next",  32'(up_EN_next),  32'(e_en_next));
            check("up_next_k",   up_next_k,        m_k);
            check("RDY_get",     32'(RDY_get),     32'(e_rdy_get));
            check("get",         get,              e_get);
            check("sum",         sum,              m_sum);
        end
        if (up_EN_next)  n_fire++;
        if (up_EN_start) n_start++;
        if (EN_get && RDY_get) dut_got.push_back(get);
        @(posedge CLK);
        if (!RST_N) begin
            m_left = 0; m_started = 0; m_q.delete(); m_sum = 0; m_k = 0;
        end else begin
            if (EN_get && m_q.size() != 0) void'(m_q.pop_front());
            if (e_en_next) begin
                m_q.push_back(up_next);
                m_sum += up_next;
                m_left--;
                if (use_gen) gen_idx++;
            end
            if (e_en_start) m_started = 1;
            if (!e_busy && EN_run && run_count != 0) begin
                m_left = int'(run_count); m_started = 0; m_k = run_k; m_sum = 0;
            end
        end
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        EN_run = 0; run_count = 0; run_k = 0; up_RDY_start = 0;
        up_RDY_next = 0; up_next = 0; EN_get = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST_N = 0;
        tick(1);
        RST_N = 1;
        n_fire = 0; n_start = 0; dut_got.delete(); gen_idx = 0;
    endtask

    typedef struct {
        logic        en_run;
        logic [7:0]  cnt;
        logic [31:0] k;
        logic        rs;
        logic        rn;
        logic [31:0] nx;
        logic        eg;
        logic        x_rdy_run;
        logic        x_es;
        logic        x_en;
        logic [31:0] x_k;
        logic        x_rg;
        logic [31:0] x_get;
        logic [31:0] x_sum;
    } vec_t;

    vec_t vecs[7];

    initial begin
        m_left = 0; m_started = 0; m_sum = 0; m_k = 0;
        use_gen = 0; gen_idx = 0; n_fire = 0; n_start = 0;

        // Basic run: k=5, samples 10/20/30, get every cycle.
        vecs[0] = '{1'b1, 8'd3, 32'd5, 1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,  32'd0};
        vecs[1] = '{1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 1'b0, 32'd0,  32'd0};
        vecs[2] = '{1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 32'd10, 1'b1, 1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 32'd0,  32'd0};
        vecs[3] = '{1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 32'd20, 1'b1, 1'b0, 1'b0, 1'b1, 32'd5, 1'b1, 32'd10, 32'd10};
        vecs[4] = '{1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 32'd30, 1'b1, 1'b0, 1'b0, 1'b1, 32'd5, 1'b1, 32'd20, 32'd30};
        vecs[5] = '{1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 32'd99, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 1'b1, 32'd30, 32'd60};
        vecs[6] = '{1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'd5, 1'b0, 32'd0,  32'd60};

        // 1. Reset with random inputs for two edges, then check while still in reset.
        RST_N = 0;
        for (int i = 0; i < 3; i++) begin
            EN_run = 1'($urandom); run_count = 8'($urandom); run_k = $urandom;
            up_RDY_start = 1'($urandom); up_RDY_next = 1'($urandom);
            up_next = $urandom; EN_get = 1'($urandom);
            tick(i == 2);
        end
        check("reset_RDY_run", 32'(RDY_run), 32'd1);
        check("reset_sum", sum, 32'd0);
        RST_N = 1;
        idle_inputs();

        // 2. Basic run from the vector table.
        for (int i = 0; i < 7; i++) begin
            EN_run = vecs[i].en_run; run_count = vecs[i].cnt; run_k = vecs[i].k;
            up_RDY_start = vecs[i].rs; up_RDY_next = vecs[i].rn;
            up_next = vecs[i].nx; EN_get = vecs[i].eg;
            #1;
            check($sformatf("vec%0d_RDY_run", i),     32'(RDY_run),     32'(vecs[i].x_rdy_run));
            check($sformatf("vec%0d_up_EN_start", i), 32'(up_EN_start), 32'(vecs[i].x_es));
            check($sformatf("vec%0d_up_EN_next", i),  32'(up_EN_next),  32'(vecs[i].x_en));
            check($sformatf("vec%0d_up_next_k", i),   up_next_k,        vecs[i].x_k);
            check($sformatf("vec%0d_RDY_get", i),     32'(RDY_get),     32'(vecs[i].x_rg));
            check($sformatf("vec%0d_get", i),         get,              vecs[i].x_get);
            check($sformatf("vec%0d_sum", i),         sum,              vecs[i].x_sum);
            tick(1);
        end

        // 3. Backpressure: six samples, no gets until the FIFO stalls.
        use_gen = 1;
        do_reset();
        gen_vals = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
        EN_run = 1; run_count = 6; run_k = 7;
        tick(1);
        EN_run = 0; up_RDY_start = 1; up_RDY_next = 1;
        repeat (10) tick(1);
        check("bp_fires_before_get", 32'(n_fire), 32'd4);
        check("bp_RDY_get", 32'(RDY_get), 32'd1);
        EN_get = 1;
        tick(1);
        EN_get = 0;
        check("bp_no_fire_in_pop_cycle", 32'(n_fire), 32'd4);
        tick(1);
        check("bp_one_fire_after_pop", 32'(n_fire), 32'd5);
        repeat (3) tick(1);
        check("bp_still_one_fire", 32'(n_fire), 32'd5);
        EN_get = 1;
        repeat (12) tick(1);
        EN_get = 0;
        check("bp_drain_count", 32'(dut_got.size()), 32'd6);
        for (int i = 0; i < 6 && i < dut_got.size(); i++)
            check($sformatf("bp_drain_%0d", i), dut_got[i], gen_vals[i]);
        check("bp_sum", sum, 32'h165);

        // 4. Generator stalls: start not ready for five cycles, next ready every other cycle.
        do_reset();
        gen_vals = '{32'd1, 32'd2, 32'd3, 32'd4};
        EN_run = 1; run_count = 4; run_k = 32'hABCD;
        tick(1);
        EN_run = 0; up_RDY_next = 1;
        repeat (5) tick(1);
        check("stall_no_start", 32'(n_start), 32'd0);
        check("stall_no_next", 32'(n_fire), 32'd0);
        up_RDY_start = 1;
        tick(1);
        up_RDY_start = 0; EN_get = 1;
        for (int i = 0; i < 12; i++) begin
            up_RDY_next = (i % 2 == 0);
            tick(1);
        end
        check("stall_one_start", 32'(n_start), 32'd1);
        check("stall_fires", 32'(n_fire), 32'd4);
        check("stall_sum", sum, 32'd10);
        check("stall_idle", 32'(busy), 32'd0);

        // 5. Ignored run while busy, zero-count run, and sum wrap.
        do_reset();
        gen_vals = '{32'hFFFF_FFFF, 32'd2};
        EN_run = 1; run_count = 2; run_k = 32'd9;
        up_RDY_start = 1; up_RDY_next = 1; EN_get = 1;
        tick(1);
        run_count = 5; run_k = 32'd77;
        tick(1);
        tick(1);
        EN_run = 0;
        tick(1);
        check("wrap_sum", sum, 32'd1);
        check("wrap_idle", 32'(RDY_run), 32'd1);
        check("busy_run_ignored_k", up_next_k, 32'd9);
        EN_run = 1; run_count = 0; run_k = 32'd55;
        tick(1);
        EN_run = 0;
        tick(1);
        check("zero_run_idle", 32'(busy), 32'd0);
        check("zero_run_sum", sum, 32'd1);
        check("zero_run_k", up_next_k, 32'd9);

        // 6. Reset during STREAM with three entries buffered, then a fresh basic run.
        do_reset();
        gen_vals = '{32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12, 32'd13, 32'd14};
        EN_run = 1; run_count = 8; run_k = 32'd3;
        tick(1);
        EN_run = 0; up_RDY_start = 1; up_RDY_next = 1;
        repeat (4) tick(1);
        check("mid_buffered", 32'(RDY_get), 32'd1);
        check("mid_streaming", 32'(busy), 32'd1);
        do_reset();
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_RDY_get", 32'(RDY_get), 32'd0);
        check("mid_reset_sum", sum, 32'd0);
        check("mid_reset_k", up_next_k, 32'd0);
        gen_vals = '{32'd10, 32'd20, 32'd30};
        EN_run = 1; run_count = 3; run_k = 32'd5;
        tick(1);
        EN_run = 0; up_RDY_start = 1; up_RDY_next = 1; EN_get = 1;
        repeat (8) tick(1);
        check("rerun_starts", 32'(n_start), 32'd1);
        check("rerun_fires", 32'(n_fire), 32'd3);
        check("rerun_count", 32'(dut_got.size()), 32'd3);
        for (int i = 0; i < 3 && i < dut_got.size(); i++)
            check($sformatf("rerun_get_%0d", i), dut_got[i], gen_vals[i]);
        check("rerun_sum", sum, 32'd60);

        // Randomized traffic against the model, including occasional resets.
        use_gen = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            RST_N        = ($urandom_range(0, 79) != 0);
            EN_run       = ($urandom_range(0, 3) == 0);
            run_count    = 8'($urandom_range(0, 9));
            run_k        = $urandom;
            up_RDY_start = ($urandom_range(0, 2) != 0);
            up_RDY_next  = ($urandom_range(0, 3) != 0);
            up_next      = $urandom;
            EN_get       = ($urandom_range(0, 2) == 0);
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_collector.md
# seq_collector

Downstream driver/consumer for the `start`/`next` sequence generator.
- Accepts a `run` command carrying a sample count and a `k` argument.
- Calls the generator's `start` method once, then calls `next` repeatedly and buffers each returned 32-bit value in a small FIFO.
- Keeps a running sum of the values and presents them to the next stage through a `get` method.
- Uses the same method-style `EN_`/`RDY_` handshakes as the generator.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `CNT_W`, 8: width of the sample count.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST_N`  in  1  reset. **One clock; reset is synchronous and active-low.**
- `EN_run`  in  1  run method enable; ignored unless `RDY_run`.
- `run_count`  in  CNT_W  number of samples to collect.
- `run_k`  in  32  argument forwarded as `up_next_k`.
- `RDY_run`  out  1  high only in IDLE.
- `up_EN_start`  out  1  generator `start` enable.
- `up_RDY_start`  in  1  generator `start` ready.
- `up_next_k`  out  32  latched `run_k`.
- `up_EN_next`  out  1  generator `next` enable.
- `up_next`  in  32  generator result; valid in the cycle `up_EN_next` is high.
- `up_RDY_next`  in  1  generator `next` ready.
- `EN_get`  in  1  get method enable; ignored unless `RDY_get`.
- `get`  out  32  FIFO head; 0 when empty.
- `RDY_get`  out  1  FIFO not empty.
- `sum`  out  32  modulo-2^32 sum of the samples collected in the current/last run.
- `busy`  out  1  state is not IDLE.

## Operation
FSM states:
- **IDLE**
  - `EN_run` with `run_count` ≠ 0: latch count into `remaining` and `run_k` into `k_q`; clear `sum`; go to START.
  - `run_count` = 0: no-op; stay in IDLE; `sum` unchanged.
- **START**
  - `up_EN_start = up_RDY_start`.
  - On the edge where it is high, go to STREAM.
- **STREAM**
  - Fire condition: `up_EN_next = up_RDY_next && !full`.
  - On each fire: push `up_next`, `sum += up_next` (wraps), `remaining -= 1`.
  - Fire with `remaining` = 1 → IDLE.

Other rules:
- `up_EN_start` and `up_EN_next` are never high outside their state. They are never high together.
- `up_next_k` holds `k_q` at all times (reset value 0). It is updated only when a run is accepted.
- FIFO:
  - Push and pop in the same cycle are both performed; the count is unchanged.
  - The full check uses the registered full flag, so a pop does not enable a push in the same cycle.
  - Pointers wrap modulo `DEPTH`.
- FIFO contents persist across runs. A new run may start while old data is still unread.
- `EN_run` while busy and `EN_get` while empty have no effect.

## Timing
- Reset values: `RDY_run`=1, `up_EN_start`=0, `up_EN_next`=0, `up_next_k`=0, `RDY_get`=0, `get`=0, `sum`=0, `busy`=0.
- Reset mid-operation: any rising edge with `RST_N`=0 returns the block to IDLE and empties the FIFO. Outputs show reset values from the following cycle.
- Run accepted at edge t → `up_EN_start` can be high in cycle t+1.
- Start fires at edge s → first `up_EN_next` can be high in cycle s+1.
- Throughput: one sample per cycle when the generator is ready and the FIFO is not full.
- Sample pushed at edge p → `RDY_get`/`get` reflect it in cycle p+1. There is no FIFO bypass.
- Last fire at edge e → `RDY_run`=1 and `busy`=0 in cycle e+1. The final `sum` is valid at that point.
- All outputs are functions of registered state plus `up_RDY_*`. There is no combinational path from `EN_get`/`EN_run` to any output.

## Structure
- Shared package `seq_pkg`:
  - FSM state enum (IDLE/START/STREAM).
  - Data width constant 32.
  - Default `DEPTH`/`CNT_W`.
- One sub-module, `seq_fifo`:
  - Parameterised by `DEPTH` and width.
  - Ports: push, pop, head, full, empty.
  - The FSM, count and sum live in `seq_collector`.

## Test plan
1. **Reset:** hold `RST_N`=0 for 2 edges with random inputs → all outputs at reset values, `RDY_run`=1.
2. **Basic run:** generator model returns 10, 20, 30; `run_count`=3, `run_k`=5, get every cycle → exactly one `up_EN_start`; 3 `up_EN_next` pulses with `up_next_k`=5; `get` sequence 10/20/30; `sum`=60; `busy` falls the cycle after the third fire.
3. **Backpressure:** `run_count`=6, no `EN_get` → exactly 4 fires, then stall with `RDY_get`=1. Then one get → exactly one more fire, two cycles later. Draining all → 6 values in order.
4. **Generator stalls:** `up_RDY_start`=0 for 5 cycles, then `up_RDY_next` toggling 1/0 → no `up_EN_start` until ready; fires only in ready cycles; no `up_EN_next` before start fires.
5. **Ignored commands and wrap:**
   - `EN_run` while busy → ignored.
   - `run_count`=0 → stays IDLE.
   - Values 0xFFFFFFFF, 2 → `sum`=1.
6. **Reset mid-run:** `RST_N` low for one edge during STREAM with 3 entries buffered → next cycle IDLE, `RDY_get`=0, `sum`=0. A new run then behaves as in test 2.
